odo_round_key_stage: RTL

- Registered stage directly downstream of the OdoCrypt rotation/mix stage. It consumes that stage's 640-bit state, which is 10 words of 64 bits, with word i at bits [64i+63:64i].
- XORs a per-round 64-bit key into every word and presents the result to the next round through a valid/ready handshake.
- Holds a small writable round-key table and a 2-entry skid buffer, so a registered in_ready still allows full throughput.

---
 rtl/odo_round_key_stage.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/odo_round_key_stage.sv
// -----------------------------------------------------------------------------
// odo_round_key_stage
//   Registered OdoCrypt round-key stage. It XORs a per-round 64-bit key, rotated
//   differently for each of the 10 words, into a 640-bit state. A 2-entry skid
//   buffer lets in_ready be a register while still sustaining one item per cycle.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake (in_ready is registered)
//   in_state, in_round  640-bit state and round index from the rotation stage
//   out_valid/out_ready downstream handshake
//   out_state           keyed state
//   out_round/out_last  round index of out_state, flag for the final round
//   key_we/addr/data    round-key table write port
//   err_round           sticky flag: an out-of-range round index was accepted
// -----------------------------------------------------------------------------
module odo_round_key_stage #(
  parameter int ROUNDS   = 12,
  parameter int RIDX_W   = 5,
  parameter int ROT_STEP = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [639:0]      in_state,
  input  logic [RIDX_W-1:0] in_round,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [639:0]      out_state,
  output logic [RIDX_W-1:0] out_round,
  output logic              out_last,
  input  logic              key_we,
  input  logic [RIDX_W-1:0] key_addr,
  input  logic [63:0]       key_data,
  output logic              err_round
);

  localparam int NWORDS = 10;

  typedef enum logic [1:0] {ST_EMPTY, ST_FULL1, ST_FULL2} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_in_ready;
  logic [63:0]         r_key [ROUNDS];
  logic [639:0]        r_out_state,  r_skid_state;
  logic [RIDX_W-1:0]   r_out_round,  r_skid_round;
  logic                r_out_last,   r_skid_last;
  logic                r_err_round;

  logic                w_accept;
  logic                w_xfer;
  logic [63:0]         w_key;
  logic                w_round_bad;
  logic                w_last;
  logic [639:0]        w_keyed;

  function automatic logic [63:0] rotl64(input logic [63:0] v, input int s);
    // s == 0 makes both shift terms v itself, so no special case is needed.
    return (v << s) | (v >> ((64 - s) % 64));
  endfunction

  assign w_accept = in_valid & r_in_ready;
  assign w_xfer   = out_valid & out_ready;

  // Table lookup by compare rather than direct index: out-of-range rounds
  // simply match nothing and fall through to a zero key.
  always_comb begin
    w_key = '0;
    for (int i = 0; i < ROUNDS; i++) begin
      if (in_round == RIDX_W'(i)) w_key = r_key[i];
    end
  end

  assign w_round_bad = {1'b0, in_round} >= (RIDX_W + 1)'(ROUNDS);
  assign w_last      = in_round == RIDX_W'(ROUNDS - 1);

  for (genvar g = 0; g < NWORDS; g++) begin : g_word
    assign w_keyed[64*g +: 64] = in_state[64*g +: 64] ^ rotl64(w_key, (ROT_STEP * g) % 64);
  end

  // ---------------------------------------------------------------------------
  // Occupancy FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      // Ready is derived from the next state so it is registered yet exact.
      r_in_ready <= (w_state_nxt != ST_FULL2);
    end
  end

  // Occupancy FSM: next-state logic
  // NOTE: the default assignment up front keeps this block latch-free.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL1;
      ST_FULL1: begin
        if (w_accept && !w_xfer)      w_state_nxt = ST_FULL2;
        else if (!w_accept && w_xfer) w_state_nxt = ST_EMPTY;
      end
      ST_FULL2: if (w_xfer) w_state_nxt = ST_FULL1;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // Occupancy FSM: outputs
  always_comb begin
    out_valid = (r_state != ST_EMPTY);
  end

  // ---------------------------------------------------------------------------
  // Output and skid registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_state  <= '0;
      r_out_round  <= '0;
      r_out_last   <= 1'b0;
      r_skid_state <= '0;
      r_skid_round <= '0;
      r_skid_last  <= 1'b0;
    end else begin
      if (r_state == ST_FULL2 && w_xfer) begin
        r_out_state <= r_skid_state;
        r_out_round <= r_skid_round;
        r_out_last  <= r_skid_last;
      end else if (w_accept && (r_state == ST_EMPTY || w_xfer)) begin
        r_out_state <= w_keyed;
        r_out_round <= in_round;
        r_out_last  <= w_last;
      end
      if (w_accept && r_state == ST_FULL1 && !w_xfer) begin
        r_skid_state <= w_keyed;
        r_skid_round <= in_round;
        r_skid_last  <= w_last;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round-key table and error flag
  // ---------------------------------------------------------------------------
  // NOTE: the key table is reset explicitly because a cleared table is
  // observable behaviour, not just initialisation; it costs a reset net per bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROUNDS; i++) r_key[i] <= '0;
      r_err_round <= 1'b0;
    end else begin
      // Out-of-range addresses match no entry and are dropped.
      for (int i = 0; i < ROUNDS; i++) begin
        if (key_we && key_addr == RIDX_W'(i)) r_key[i] <= key_data;
      end
      if (w_accept && w_round_bad) r_err_round <= 1'b1;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_state = r_out_state;
  assign out_round = r_out_round;
  assign out_last  = r_out_last;
  assign err_round = r_err_round;

endmodule
